// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared states and constants for the pong ball engine
package pong_pkg;

    typedef enum logic [1:0] {
        ST_SERVE = 2'b00,
        ST_MOVE  = 2'b01,
        ST_MISS  = 2'b10
    } ball_state_e;

    localparam int X_MAX     = 1008;
    localparam int Y_MAX     = 752;
    localparam int X_CENTRE  = 504;
    localparam int Y_CENTRE  = 376;
    localparam int BALL_SIZE = 16;
    localparam int PADDLE_X  = 20;
    localparam int PADDLE_W  = 10;
    localparam int PADDLE_H  = 100;

    localparam int ZONE_HIGH = 16;
    localparam int ZONE_MED  = 48;

    localparam logic signed [4:0] SERVE_VX = -5'sd4;
    localparam logic signed [4:0] VX_HIGH  = 5'sd6;
    localparam logic signed [4:0] VY_HIGH  = 5'sd1;
    localparam logic signed [4:0] VX_MED   = 5'sd4;
    localparam logic signed [4:0] VY_MED   = 5'sd3;
    localparam logic signed [4:0] VX_LOW   = 5'sd3;
    localparam logic signed [4:0] VY_LOW   = 5'sd5;

endpackage

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - movement tick divider, one-cycle pulse every TICK_DIV clocks
module tick_gen #(
    parameter int TICK_DIV = 650_000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] cnt;

    assign tick = (cnt == CW'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/pong_ball_ctl.sv
// rtl/pong_ball_ctl.sv - ball position/velocity FSM with wall and paddle reflection
module pong_ball_ctl
    import pong_pkg::*;
#(
    parameter int TICK_DIV    = 650_000,
    parameter int SERVE_TICKS = 100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] rect_y_pos,
    input  logic [3:0]  random_4,
    output logic [10:0] xpos,
    output logic [10:0] ypos
);

    localparam int SW = (SERVE_TICKS > 1) ? $clog2(SERVE_TICKS) : 1;

    localparam logic signed [12:0] PAD_EDGE = 13'(PADDLE_X + PADDLE_W);
    localparam logic signed [12:0] XMAX_S   = 13'(X_MAX);
    localparam logic signed [12:0] YMAX_S   = 13'(Y_MAX);
    localparam logic signed [12:0] ZHIGH_S  = 13'(ZONE_HIGH);
    localparam logic signed [12:0] ZMED_S   = 13'(ZONE_MED);

    ball_state_e       state;
    logic [SW-1:0]     serve_cnt;
    logic signed [4:0] vx, vy;
    logic              tick;

    logic signed [12:0] xs, ys, ry, nx, ny, off, off_abs;
    logic               overlap, paddle_hit, miss_hit, right_hit, y_flip;
    logic signed [4:0]  pad_vx, pad_mag, pad_vy, serve_vy;

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // 13-bit signed keeps the unclamped paddle position and overshoots in range
    assign xs      = $signed({2'b00, xpos});
    assign ys      = $signed({2'b00, ypos});
    assign ry      = $signed({2'b00, rect_y_pos});
    assign nx      = xs + $signed({{8{vx[4]}}, vx});
    assign ny      = ys + $signed({{8{vy[4]}}, vy});
    assign overlap = (ys + 13'(BALL_SIZE - 1) >= ry) && (ys <= ry + 13'(PADDLE_H - 1));
    assign off     = (ys + 13'(BALL_SIZE / 2)) - (ry + 13'(PADDLE_H / 2));
    assign off_abs = off[12] ? -off : off;

    assign paddle_hit = vx[4] && (nx <= PAD_EDGE) && overlap;
    assign miss_hit   = vx[4] && (nx <= 13'sd0) && !overlap;
    assign right_hit  = (nx >= XMAX_S);
    assign y_flip     = (ny <= 13'sd0) || (ny >= YMAX_S);

    always_comb begin
        pad_vx  = VX_LOW;
        pad_mag = VY_LOW;
        if (off_abs < ZHIGH_S) begin
            pad_vx  = VX_HIGH;
            pad_mag = VY_HIGH;
        end else if (off_abs < ZMED_S) begin
            pad_vx  = VX_MED;
            pad_mag = VY_MED;
        end
    end

    assign pad_vy   = (off == 13'sd0) ? 5'sd0 : (off[12] ? -pad_mag : pad_mag);
    assign serve_vy = random_4[3] ? -$signed({3'b000, random_4[1:0]})
                                  :  $signed({3'b000, random_4[1:0]});

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_SERVE;
            serve_cnt <= '0;
            xpos      <= 11'(X_CENTRE);
            ypos      <= 11'(Y_CENTRE);
            vx        <= '0;
            vy        <= '0;
        end else if (tick) begin
            case (state)
                ST_SERVE: begin
                    if (serve_cnt == SW'(SERVE_TICKS - 1)) begin
                        serve_cnt <= '0;
                        vx        <= SERVE_VX;
                        vy        <= serve_vy;
                        state     <= ST_MOVE;
                    end else begin
                        serve_cnt <= serve_cnt + SW'(1);
                    end
                end
                ST_MOVE: begin
                    if (paddle_hit) begin
                        xpos <= 11'(PADDLE_X + PADDLE_W);
                        vx   <= pad_vx;
                    end else if (miss_hit) begin
                        xpos      <= '0;
                        serve_cnt <= '0;
                        state     <= ST_MISS;
                    end else if (right_hit) begin
                        xpos <= 11'(X_MAX);
                        vx   <= -vx;
                    end else begin
                        xpos <= nx[10:0];
                    end
                    // a paddle hit sets a fresh vertical speed, overriding a wall flip
                    if (ny <= 13'sd0)       ypos <= '0;
                    else if (ny >= YMAX_S)  ypos <= 11'(Y_MAX);
                    else                    ypos <= ny[10:0];
                    if (paddle_hit)         vy <= pad_vy;
                    else if (y_flip)        vy <= -vy;
                end
                ST_MISS: begin
                    if (serve_cnt == SW'(SERVE_TICKS - 1)) begin
                        serve_cnt <= '0;
                        xpos      <= 11'(X_CENTRE);
                        ypos      <= 11'(Y_CENTRE);
                        state     <= ST_SERVE;
                    end else begin
                        serve_cnt <= serve_cnt + SW'(1);
                    end
                end
                default: state <= ST_SERVE;
            endcase
        end
    end

endmodule

// File: tb/tb_pong_ball_ctl.sv
// tb/tb_pong_ball_ctl.sv - randomized bench for pong_ball_ctl against a behavioural ball model
module tb_pong_ball_ctl;

    localparam int SERVE_TICKS = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] rect_y_pos;
    logic [3:0]  random_4;
    logic [10:0] xpos, ypos;

    int total = 0;
    int bad   = 0;

    // model: phase 0 serve, 1 move, 2 miss
    int m_x, m_y, m_vx, m_vy, m_phase, m_cnt;

    pong_ball_ctl #(.TICK_DIV(1), .SERVE_TICKS(SERVE_TICKS)) dut (
        .clk        (clk),
        .rst        (rst),
        .rect_y_pos (rect_y_pos),
        .random_4   (random_4),
        .xpos       (xpos),
        .ypos       (ypos)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s obs=%0d exp=%0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_x = 504; m_y = 376; m_vx = 0; m_vy = 0; m_phase = 0; m_cnt = 0;
    endfunction

    function automatic void model_step(input int ry, input int r4);
        int nx, ny, off, aoff, new_vy;
        bit ovl, pad, flip;
        case (m_phase)
            0: begin
                m_cnt++;
                if (m_cnt == SERVE_TICKS) begin
                    m_vx = -4;
                    m_vy = ((r4 >> 3) & 1) ? -(r4 & 3) : (r4 & 3);
                    m_phase = 1;
                    m_cnt = 0;
                end
            end
            1: begin
                nx = m_x + m_vx;
                ny = m_y + m_vy;
                ovl = (m_y + 15 >= ry) && (m_y <= ry + 99);
                pad = 0;
                new_vy = m_vy;
                if (m_vx < 0 && nx <= 30 && ovl) begin
                    pad = 1;
                    m_x = 30;
                    off = (m_y + 8) - (ry + 50);
                    aoff = off < 0 ? -off : off;
                    if (aoff < 16)      begin m_vx = 6; new_vy = 1; end
                    else if (aoff < 48) begin m_vx = 4; new_vy = 3; end
                    else                begin m_vx = 3; new_vy = 5; end
                    if (off < 0) new_vy = -new_vy;
                    else if (off == 0) new_vy = 0;
                end else if (m_vx < 0 && nx <= 0) begin
                    m_x = 0;
                    m_phase = 2;
                    m_cnt = 0;
                end else if (nx >= 1008) begin
                    m_x = 1008;
                    m_vx = -m_vx;
                end else begin
                    m_x = nx;
                end
                flip = 1;
                if (ny <= 0)        m_y = 0;
                else if (ny >= 752) m_y = 752;
                else begin          m_y = ny; flip = 0; end
                if (pad)       m_vy = new_vy;
                else if (flip) m_vy = -m_vy;
            end
            default: begin
                m_cnt++;
                if (m_cnt == SERVE_TICKS) begin
                    m_x = 504; m_y = 376; m_phase = 0; m_cnt = 0;
                end
            end
        endcase
    endfunction

    // one tick per cycle: step the model for the edge just taken, then compare
    task automatic step_and_check(input string tag);
        @(negedge clk);
        model_step(int'(rect_y_pos), int'(random_4));
        check({tag, "_x"}, int'(xpos), m_x);
        check({tag, "_y"}, int'(ypos), m_y);
        check({tag, "_st"}, int'(dut.state), m_phase);
    endtask

    task automatic do_reset();
        #2 rst = 1'b0;
        #1;
        check("rst_x", int'(xpos), 504);
        check("rst_y", int'(ypos), 376);
        check("rst_st", int'(dut.state), 0);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
    endtask

    task automatic run_fixed(input string tag, input int ry, input int r4, input int n);
        rect_y_pos = 11'(ry);
        random_4   = 4'(r4);
        for (int i = 0; i < n; i++) step_and_check(tag);
    endtask

    initial begin
        rst = 1'b0;
        rect_y_pos = 11'd334;
        random_4 = 4'd0;
        repeat (3) @(negedge clk);
        check("init_x", int'(xpos), 504);
        check("init_y", int'(ypos), 376);
        check("init_st", int'(dut.state), 0);
        rst = 1'b1;
        model_reset();

        // serve, first move step, then HIGH bounce and right wall
        for (int i = 0; i < 3; i++) step_and_check("serve");
        check("first_move_x", int'(xpos), 500);
        check("first_move_y", int'(ypos), 376);
        run_fixed("high", 334, 0, 700);

        do_reset();
        run_fixed("low", 384, 0, 400);

        do_reset();
        run_fixed("miss", 0, 0, 300);

        do_reset();
        run_fixed("top", 600, 4'b1011, 400);

        for (int seg = 0; seg < 8; seg++) begin
            int ry;
            do_reset();
            ry = $urandom_range(0, 767);
            for (int i = 0; i < 500; i++) begin
                random_4 = 4'($urandom_range(0, 15));
                if (seg % 2 == 0) begin
                    ry = m_y - 42 + $urandom_range(0, 120) - 60;
                    if (ry < 0) ry = 0;
                end
                rect_y_pos = 11'(ry);
                step_and_check("rand");
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
